// File: rtl/mac_tx_arbiter.sv
// Two-port whole-packet round-robin arbiter feeding the teng_mac AXIS TX port.
// Each grant pushes the port ID into an in-order FIFO so MAC responses return to the sender.

module mac_tx_pkt_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             s_user_clk,
  input  logic             r_global_rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge s_user_clk or negedge r_global_rst)
    if (!r_global_rst) cnt <= '0;
    else if (inc)      cnt <= cnt + 1'b1;
endmodule

module mac_tx_arbiter #(
  parameter int DATA_W    = 32,
  parameter int VLDB_W    = 2,
  parameter int RSP_DEPTH = 4,
  parameter int CNT_W     = 16
) (
  input  logic              s_user_clk,
  input  logic              r_global_rst,
  input  logic [DATA_W-1:0] s0_data_i,
  input  logic [VLDB_W-1:0] s0_vldb_i,
  input  logic              s0_valid_i,
  input  logic              s0_last_i,
  input  logic              s0_user_i,
  output logic              s0_ready_o,
  input  logic [DATA_W-1:0] s1_data_i,
  input  logic [VLDB_W-1:0] s1_vldb_i,
  input  logic              s1_valid_i,
  input  logic              s1_last_i,
  input  logic              s1_user_i,
  output logic              s1_ready_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic [VLDB_W-1:0] m_vldb_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  output logic              m_user_o,
  input  logic              m_ready_i,
  input  logic              tx_rsp_valid_i,
  input  logic              tx_status_i,
  output logic              s0_rsp_valid_o,
  output logic              s0_rsp_status_o,
  output logic              s1_rsp_valid_o,
  output logic              s1_rsp_status_o,
  output logic [CNT_W-1:0]  s0_pkt_cnt_o,
  output logic [CNT_W-1:0]  s1_pkt_cnt_o,
  output logic              rsp_orphan_o
);
  localparam int NUM_PORTS = 2;
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  logic [NUM_PORTS-1:0][DATA_W-1:0] s_data;
  logic [NUM_PORTS-1:0][VLDB_W-1:0] s_vldb;
  logic [NUM_PORTS-1:0]             s_valid, s_last, s_user, s_ready, done;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  pkt_cnt;

  state_t          state, nxt;
  logic            rr, gsel, push, push_id, pop, head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [RSP_DEPTH-1:0] id_mem;
  logic            fifo_empty, fifo_full;
  logic [NUM_PORTS-1:0] rsp_vld;
  logic            rsp_st;

  assign s_data  = {s1_data_i,  s0_data_i};
  assign s_vldb  = {s1_vldb_i,  s0_vldb_i};
  assign s_valid = {s1_valid_i, s0_valid_i};
  assign s_last  = {s1_last_i,  s0_last_i};
  assign s_user  = {s1_user_i,  s0_user_i};
  assign s0_ready_o = s_ready[0];
  assign s1_ready_o = s_ready[1];

  assign gsel       = (state == GRANT1);
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = tx_rsp_valid_i && !fifo_empty;
  assign head       = id_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge s_user_clk or negedge r_global_rst)
    if (!r_global_rst) begin
      state <= IDLE;
      rr    <= 1'b1;
    end else begin
      state <= nxt;
      if (push) rr <= push_id;
    end

  // Zero-latency pass-through of the granted port; idle drives all-zero.
  always_comb begin
    nxt       = state;
    push      = 1'b0;
    push_id   = 1'b0;
    done      = '0;
    s_ready   = '0;
    m_data_o  = '0;
    m_vldb_o  = '0;
    m_valid_o = 1'b0;
    m_last_o  = 1'b0;
    m_user_o  = 1'b0;
    case (state)
      IDLE:
        if (!fifo_full && (|s_valid)) begin
          push    = 1'b1;
          push_id = (&s_valid) ? ~rr : s_valid[1];
          nxt     = push_id ? GRANT1 : GRANT0;
        end
      GRANT0, GRANT1: begin
        m_data_o       = s_data[gsel];
        m_vldb_o       = s_vldb[gsel];
        m_valid_o      = s_valid[gsel];
        m_last_o       = s_last[gsel];
        m_user_o       = s_user[gsel];
        s_ready[gsel]  = m_ready_i;
        if (s_valid[gsel] && m_ready_i && s_last[gsel]) begin
          done[gsel] = 1'b1;
          nxt        = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge s_user_clk or negedge r_global_rst)
    if (!r_global_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      id_mem <= '0;
    end else begin
      if (push) begin
        id_mem[wr_ptr[AW-1:0]] <= push_id;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end

  // Response demux: one-cycle pulse to the port at the FIFO head.
  always_ff @(posedge s_user_clk or negedge r_global_rst)
    if (!r_global_rst) begin
      rsp_vld      <= '0;
      rsp_st       <= 1'b0;
      rsp_orphan_o <= 1'b0;
    end else begin
      rsp_vld <= '0;
      if (pop) begin
        rsp_vld <= head ? 2'b10 : 2'b01;
        rsp_st  <= tx_status_i;
      end
      if (tx_rsp_valid_i && fifo_empty) rsp_orphan_o <= 1'b1;
    end

  assign s0_rsp_valid_o  = rsp_vld[0];
  assign s1_rsp_valid_o  = rsp_vld[1];
  assign s0_rsp_status_o = rsp_st & rsp_vld[0];
  assign s1_rsp_status_o = rsp_st & rsp_vld[1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ctr
    mac_tx_pkt_ctr #(.CNT_W(CNT_W)) u_ctr (
      .s_user_clk  (s_user_clk),
      .r_global_rst(r_global_rst),
      .inc         (done[p]),
      .cnt         (pkt_cnt[p])
    );
  end

  assign s0_pkt_cnt_o = pkt_cnt[0];
  assign s1_pkt_cnt_o = pkt_cnt[1];
endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: packet-level model (queue of outstanding IDs,
// current owner, counters) compared every cycle, plus literal per-test expectations.

module tb_mac_tx_arbiter;
  localparam int DW = 32, VW = 2, DEPTH = 4, CW = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] s0_data, s1_data, m_data;
  logic [VW-1:0] s0_vldb, s1_vldb, m_vldb;
  logic s0_valid, s0_last, s0_user, s0_ready, s1_valid, s1_last, s1_user, s1_ready;
  logic m_valid, m_last, m_user, m_ready, tx_rsp_valid, tx_status;
  logic s0_rv, s0_rs, s1_rv, s1_rs, orphan;
  logic [CW-1:0] cnt0, cnt1;

  mac_tx_arbiter #(.DATA_W(DW), .VLDB_W(VW), .RSP_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .s_user_clk(clk), .r_global_rst(rst_n),
    .s0_data_i(s0_data), .s0_vldb_i(s0_vldb), .s0_valid_i(s0_valid), .s0_last_i(s0_last),
    .s0_user_i(s0_user), .s0_ready_o(s0_ready),
    .s1_data_i(s1_data), .s1_vldb_i(s1_vldb), .s1_valid_i(s1_valid), .s1_last_i(s1_last),
    .s1_user_i(s1_user), .s1_ready_o(s1_ready),
    .m_data_o(m_data), .m_vldb_o(m_vldb), .m_valid_o(m_valid), .m_last_o(m_last),
    .m_user_o(m_user), .m_ready_i(m_ready),
    .tx_rsp_valid_i(tx_rsp_valid), .tx_status_i(tx_status),
    .s0_rsp_valid_o(s0_rv), .s0_rsp_status_o(s0_rs), .s1_rsp_valid_o(s1_rv), .s1_rsp_status_o(s1_rs),
    .s0_pkt_cnt_o(cnt0), .s1_pkt_cnt_o(cnt1), .rsp_orphan_o(orphan)
  );

  int errors = 0, checks = 0, cyc = 0;

  // sources
  int plen0[$], plen1[$];
  int bidx[2], pno[2];
  bit en[2], fire[2];
  int rmode = 0;
  bit lb_en = 0, man_rsp = 0, man_st = 0;
  int due[$];

  // model
  int m_owner, m_rr, m_q[$], m_cnt[2];
  bit m_orph, m_rv[2], m_rs;

  // observations
  bit in_pkt = 0;
  int cur_beats = 0;
  int gl[$], pb[$], pv[$], rl[$];

  function automatic int plen_size(int p);
    return p ? plen1.size() : plen0.size();
  endfunction
  function automatic int plen_front(int p);
    return p ? plen1[0] : plen0[0];
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 1; m_q.delete(); m_cnt[0] = 0; m_cnt[1] = 0;
    m_orph = 0; m_rv[0] = 0; m_rv[1] = 0; m_rs = 0;
  endtask

  task automatic check_cycle();
    logic [DW-1:0] ed; logic [VW-1:0] ev; logic evl, el, eu, er0, er1; bit ok;
    ed = '0; ev = '0; evl = 0; el = 0; eu = 0; er0 = 0; er1 = 0;
    if (m_owner == 0) begin
      ed = s0_data; ev = s0_vldb; evl = s0_valid; el = s0_last; eu = s0_user; er0 = m_ready;
    end else if (m_owner == 1) begin
      ed = s1_data; ev = s1_vldb; evl = s1_valid; el = s1_last; eu = s1_user; er1 = m_ready;
    end
    ok = (m_data === ed) && (m_vldb === ev) && (m_valid === evl) && (m_last === el) &&
         (m_user === eu) && (s0_ready === er0) && (s1_ready === er1) &&
         (s0_rv === m_rv[0]) && (s1_rv === m_rv[1]) &&
         (!m_rv[0] || s0_rs === m_rs) && (!m_rv[1] || s1_rs === m_rs) &&
         (cnt0 === CW'(m_cnt[0])) && (cnt1 === CW'(m_cnt[1])) && (orphan === m_orph);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cycle_cmp @%0d: got v=%b d=%h rdy=%b%b rsp=%b%b cnt=%0d,%0d orph=%b; expected v=%b d=%h rdy=%b%b rsp=%b%b cnt=%0d,%0d orph=%b",
               cyc, m_valid, m_data, s1_ready, s0_ready, s1_rv, s0_rv, cnt1, cnt0, orphan,
               evl, ed, er1, er0, m_rv[1], m_rv[0], m_cnt[1], m_cnt[0], m_orph);
    end
  endtask

  task automatic model_update();
    bit v0, v1, grant; int w, sz, h;
    if (!rst_n) begin model_reset(); return; end
    v0 = s0_valid; v1 = s1_valid; grant = 0; w = 0; sz = m_q.size();
    if (m_owner < 0) begin
      if (sz < DEPTH && (v0 || v1)) begin
        grant = 1;
        w = (v0 && v1) ? 1 - m_rr : (v0 ? 0 : 1);
      end
    end else if (m_owner == 0 ? (v0 && m_ready && s0_last) : (v1 && m_ready && s1_last)) begin
      m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CW);
      m_owner = -1;
    end
    m_rv[0] = 0; m_rv[1] = 0;
    if (tx_rsp_valid) begin
      if (sz > 0) begin h = m_q.pop_front(); m_rv[h] = 1; m_rs = tx_status; end
      else m_orph = 1;
    end
    if (grant) begin m_owner = w; m_rr = w; m_q.push_back(w); end
  endtask

  task automatic observe();
    if (m_valid && m_ready) begin
      if (!in_pkt) begin
        in_pkt = 1; cur_beats = 0;
        gl.push_back(s1_ready ? 1 : 0);
      end
      if (m_data[15:0] != 16'(cur_beats)) chk("beat_seq", int'(m_data[15:0]), cur_beats);
      cur_beats++;
      if (m_last) begin
        pb.push_back(cur_beats); pv.push_back(int'(m_vldb)); in_pkt = 0;
        if (lb_en) due.push_back(cyc + 3);
      end
    end
    if (s0_rv) rl.push_back(int'(s0_rs));
    if (s1_rv) rl.push_back(2 + int'(s1_rs));
  endtask

  task automatic drive_port(int p);
    logic v, l, u; logic [DW-1:0] d; logic [VW-1:0] vb; int len, nb;
    v = 0; l = 0; u = 0; d = '0; vb = '0;
    if (fire[p] && plen_size(p) > 0) begin
      len = plen_front(p); nb = (len + 3) / 4; bidx[p]++;
      if (bidx[p] == nb) begin
        if (p == 0) void'(plen0.pop_front()); else void'(plen1.pop_front());
        bidx[p] = 0; pno[p]++;
      end
    end
    fire[p] = 0;
    if (en[p] && plen_size(p) > 0) begin
      len = plen_front(p); nb = (len + 3) / 4;
      v = 1; l = (bidx[p] == nb - 1);
      d = {4'(p + 1), 4'h0, 8'(pno[p]), 16'(bidx[p])};
      vb = l ? VW'((len - 1) % 4) : VW'(3);
      u = pno[p][0];
    end
    if (p == 0) begin s0_valid = v; s0_last = l; s0_data = d; s0_vldb = vb; s0_user = u; end
    else        begin s1_valid = v; s1_last = l; s1_data = d; s1_vldb = vb; s1_user = u; end
  endtask

  task automatic drive();
    drive_port(0); drive_port(1);
    if (rmode == 1) m_ready = ~m_ready; else m_ready = 1'b1;
    tx_rsp_valid = 0; tx_status = 0;
    if (due.size() > 0 && due[0] <= cyc) begin void'(due.pop_front()); tx_rsp_valid = 1; end
    if (man_rsp) begin tx_rsp_valid = 1; tx_status = man_st; man_rsp = 0; end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    observe();
    fire[0] = s0_valid && s0_ready;
    fire[1] = s1_valid && s1_ready;
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_until_idle(string name, int max);
    int i;
    for (i = 0; i < max; i++) begin
      step();
      if (plen0.size() == 0 && plen1.size() == 0 && !in_pkt) break;
    end
    if (i == max) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic pulse_rsp(bit st);
    man_rsp = 1; man_st = st; step(); step();
  endtask

  task automatic src_clear();
    plen0.delete(); plen1.delete(); due.delete();
    for (int p = 0; p < 2; p++) begin bidx[p] = 0; en[p] = 0; fire[p] = 0; end
    man_rsp = 0; in_pkt = 0;
    drive_port(0); drive_port(1);
    tx_rsp_valid = 0; tx_status = 0;
  endtask

  task automatic clear_logs();
    gl.delete(); pb.delete(); pv.delete(); rl.delete();
  endtask

  initial begin
    int code, c0;
    model_reset();
    pno[0] = 0; pno[1] = 0; m_ready = 1;
    src_clear();
    step(); step();
    chk("reset_cnt0", int'(cnt0), 0);
    chk("reset_orphan", int'(orphan), 0);
    rst_n = 1;
    step();

    // both ports busy, 4 packets each: strict alternation starting with port 0
    clear_logs(); lb_en = 1; en[0] = 1; en[1] = 1;
    repeat (4) begin plen0.push_back(64); plen1.push_back(100); end
    run_until_idle("t2", 400);
    repeat (8) step();
    code = 0;
    foreach (gl[i]) code |= gl[i] << i;
    chk("t2_grants", gl.size(), 8);
    chk("t2_order", code, 'hAA);
    chk("t2_beats0", pb[0], 16);
    chk("t2_beats1", pb[1], 25);
    chk("t2_cnt0", int'(cnt0), 4);
    chk("t2_cnt1", int'(cnt1), 4);
    chk("t2_rsps", rl.size(), 8);

    // port 0 only, 60/61/62 bytes with loopback responses
    clear_logs(); en[1] = 0;
    plen0.push_back(60); plen0.push_back(61); plen0.push_back(62);
    run_until_idle("t1", 200);
    repeat (8) step();
    chk("t1_cnt0", int'(cnt0), 7);
    chk("t1_cnt1", int'(cnt1), 4);
    chk("t1_grants", gl.size() == 3 && gl[0] == 0 && gl[1] == 0 && gl[2] == 0, 1);
    chk("t1_beats", pb[0] * 10000 + pb[1] * 100 + pb[2], 151616);
    chk("t1_vldb", pv[0] * 100 + pv[1] * 10 + pv[2], 301);
    chk("t1_rsps", rl.size() == 3 && rl[0] == 0 && rl[1] == 0 && rl[2] == 0, 1);

    // 1514-byte packet with 1010 backpressure
    clear_logs(); rmode = 1;
    plen0.push_back(1514);
    run_until_idle("t4", 1000);
    rmode = 0;
    repeat (8) step();
    chk("t4_beats", pb[0], 379);
    chk("t4_last_vldb", pv[0], 1);

    // manual responses: port 1 then port 0, then one orphan
    clear_logs(); lb_en = 0; en[0] = 0; en[1] = 1;
    plen1.push_back(12);
    run_until_idle("t5a", 50);
    en[0] = 1; en[1] = 0;
    plen0.push_back(12);
    run_until_idle("t5b", 50);
    pulse_rsp(1); pulse_rsp(0); step(); step();
    chk("t5_rsps", rl.size(), 2);
    chk("t5_first_s1_st1", rl[0], 3);
    chk("t5_second_s0", rl[1], 0);
    chk("t5_no_orphan_yet", int'(orphan), 0);
    pulse_rsp(0); step();
    chk("t5_orphan", int'(orphan), 1);

    // FIFO full stalls grants; one response releases exactly one packet
    clear_logs(); c0 = int'(cnt0);
    repeat (6) plen0.push_back(8);
    repeat (60) step();
    chk("t3_sent4", pb.size(), 4);
    chk("t3_cnt", int'(cnt0) - c0, 4);
    chk("t3_ready_low", int'(s0_ready), 0);
    pulse_rsp(0);
    repeat (20) step();
    chk("t3_sent5", pb.size(), 5);
    chk("t3_left", plen0.size(), 1);

    // clean reset, one port-0 packet, then reset mid-packet on port 1
    rst_n = 0; src_clear(); model_reset(); step(); step(); rst_n = 1; step();
    clear_logs(); lb_en = 1; en[0] = 1;
    plen0.push_back(16);
    run_until_idle("t6a", 50);
    chk("t6_cnt0_pre", int'(cnt0), 1);
    en[0] = 0; en[1] = 1;
    plen1.push_back(200);
    repeat (15) step();
    chk("t6_midpkt", int'(m_valid && s1_ready), 1);
    #2 rst_n = 0;
    src_clear(); model_reset();
    #1;
    chk("t6_rst_valid", int'(m_valid), 0);
    chk("t6_rst_ready", int'(s1_ready), 0);
    chk("t6_rst_data", int'(m_data != 0), 0);
    chk("t6_rst_cnt0", int'(cnt0), 0);
    step(); step();
    rst_n = 1;
    step();
    chk("t6_cnt0_after", int'(cnt0), 0);
    chk("t6_cnt1_after", int'(cnt1), 0);
    clear_logs(); en[0] = 1; en[1] = 1;
    plen0.push_back(8); plen1.push_back(8);
    run_until_idle("t6b", 50);
    repeat (6) step();
    chk("t6_grants", gl.size(), 2);
    chk("t6_first_port0", gl[0], 0);
    chk("t6_cnts", int'(cnt0) * 10 + int'(cnt1), 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
